// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bus for the sequential ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge and
// never waits for ready before raising valid. The consumer may change
// ready freely. This applies to the request (in_valid/in_ready carrying
// a, b, op) and to the result (out_valid/out_ready carrying r, r_hi and
// the flags).
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_hi;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             busy;

    // Request side: drives operands and takes results.
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, r, r_hi, zero, carry, negative, overflow, busy
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, r, r_hi, zero, carry, negative, overflow, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-cycle aluc ops plus iterative multiply (and divide when
// ALU_SEQ_DIV_EN is defined) behind a one-entry registered result.
// Multiply and divide work on operand magnitudes in a shared hi/lo register
// pair for WIDTH steps; the FIX state applies signs, special cases and flags.
// Without ALU_SEQ_DIV_EN the divide opcodes fall into the reserved class.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    state_t             state, state_n;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   hi, lo, mcand;
    logic               neg_q, signed_q;
    logic               accept, is_iter;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Single-cycle result path.
    logic [WIDTH:0]     sum, dif, shr, shl;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   sc_r;
    logic               sc_z, sc_c, sc_n, sc_v, use_r_flags;

    // Iteration and fix-up path.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_r, fix_hi;
    logic               fix_z, fix_c, fix_n, fix_v;

    // Result register.
    logic               out_valid_q;
    logic [WIDTH-1:0]   r_q, r_hi_q;
    logic               z_q, c_q, n_q, v_q;

`ifdef ALU_SEQ_DIV_EN
    logic               div_q, rem_neg_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff, quo, rem;
    logic               div_ge;

    assign is_iter = bus.op[4] && (bus.op[3:2] == 2'b00);
`else
    assign is_iter = bus.op[4] && (bus.op[3:1] == 3'b000);
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign sa     = bus.op[0] && bus.a[WIDTH-1];
    assign sb     = bus.op[0] && bus.b[WIDTH-1];
    assign abs_a  = sa ? -bus.a : bus.a;
    assign abs_b  = sb ? -bus.b : bus.b;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and handshake/status outputs.
    always_comb begin
        state_n      = state;
        bus.in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
        bus.busy     = (state != S_IDLE);
        case (state)
            S_IDLE:  if (accept && is_iter) state_n = S_ITER;
            S_ITER:  if (cnt == CNT_LAST)   state_n = S_FIX;
            S_FIX:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    // Single-cycle aluc operations, computed from the live request.
    always_comb begin
        sum         = {1'b0, bus.a} + {1'b0, bus.b};
        dif         = {1'b0, bus.a} - {1'b0, bus.b};
        sh          = bus.a[SHAMT_W-1:0];
        shr         = {bus.b, 1'b0} >> sh;
        shl         = {1'b0, bus.b} << sh;
        sc_r        = '0;
        sc_z        = 1'b0;
        sc_c        = 1'b0;
        sc_n        = 1'b0;
        sc_v        = 1'b0;
        use_r_flags = 1'b0;
        if (!bus.op[4]) begin
            use_r_flags = 1'b1;
            case (bus.op[3:0])
                4'b0000: begin sc_r = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; end
                4'b0010: begin
                    sc_r = sum[WIDTH-1:0];
                    sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                4'b0001: begin sc_r = dif[WIDTH-1:0]; sc_c = dif[WIDTH]; end
                4'b0011: begin
                    sc_r = dif[WIDTH-1:0];
                    sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
                end
                4'b0100: sc_r = bus.a & bus.b;
                4'b0101: sc_r = bus.a | bus.b;
                4'b0110: sc_r = bus.a ^ bus.b;
                4'b0111: sc_r = ~(bus.a | bus.b);
                4'b1000, 4'b1001: sc_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                4'b1011: begin
                    use_r_flags = 1'b0;
                    sc_n = $signed(bus.a) < $signed(bus.b);
                    sc_r = {{(WIDTH-1){1'b0}}, sc_n};
                    sc_z = (bus.a == bus.b);
                end
                4'b1010: begin
                    use_r_flags = 1'b0;
                    sc_c = dif[WIDTH];
                    sc_r = {{(WIDTH-1){1'b0}}, sc_c};
                    sc_z = (bus.a == bus.b);
                end
                4'b1100: begin
                    shr  = $signed({bus.b, 1'b0}) >>> sh;
                    sc_r = shr[WIDTH:1];
                    sc_c = shr[0];
                end
                4'b1101: begin sc_r = shr[WIDTH:1]; sc_c = shr[0]; end
                default: begin sc_r = shl[WIDTH-1:0]; sc_c = shl[WIDTH]; end
            endcase
        end
        if (use_r_flags) begin
            sc_z = (sc_r == '0);
            sc_n = sc_r[WIDTH-1];
        end
    end

    // One shift/add (multiply) or shift/subtract (divide) step on hi:lo.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift[WIDTH-1:0] - mcand;
        if (div_q) begin
            hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_step = {lo[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Sign correction, special cases and flags for the iterative result.
    always_comb begin
        prod   = neg_q ? -{hi, lo} : {hi, lo};
        fix_r  = prod[WIDTH-1:0];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_z  = (prod == '0);
        fix_c  = 1'b0;
        fix_n  = fix_hi[WIDTH-1];
        fix_v  = signed_q ? (fix_hi != {WIDTH{fix_r[WIDTH-1]}}) : (fix_hi != '0);
`ifdef ALU_SEQ_DIV_EN
        quo = neg_q ? -lo : lo;
        rem = rem_neg_q ? -hi : hi;
        if (div_q) begin
            fix_r  = quo;
            fix_hi = rem;
            fix_v  = 1'b0;
            if (b_q == '0) begin
                fix_r  = '1;
                fix_hi = a_q;
                fix_v  = 1'b1;
            end else if (signed_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) begin
                // Magnitude path already yields MIN with remainder 0.
                fix_v = 1'b1;
            end
            fix_z = (fix_r == '0);
            fix_n = fix_r[WIDTH-1];
        end
`endif
    end

    // Iterative datapath: load magnitudes at accept, step while in ITER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`endif
        end else if (accept && is_iter) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= abs_a;
            mcand    <= abs_b;
            neg_q    <= sa ^ sb;
            signed_q <= bus.op[0];
`ifdef ALU_SEQ_DIV_EN
            div_q     <= bus.op[1];
            rem_neg_q <= sa;
            a_q       <= bus.a;
            b_q       <= bus.b;
`endif
        end else if (state == S_ITER) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_step;
            lo  <= lo_step;
        end
    end

    // One-entry result register; holds while out_valid && !out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            r_hi_q      <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
        end else if (accept && !is_iter) begin
            out_valid_q <= 1'b1;
            r_q         <= sc_r;
            r_hi_q      <= '0;
            z_q         <= sc_z;
            c_q         <= sc_c;
            n_q         <= sc_n;
            v_q         <= sc_v;
        end else if (state == S_FIX) begin
            out_valid_q <= 1'b1;
            r_q         <= fix_r;
            r_hi_q      <= fix_hi;
            z_q         <= fix_z;
            c_q         <= fix_c;
            n_q         <= fix_n;
            v_q         <= fix_v;
        end else if (accept || bus.out_ready) begin
            // Iterative start also lands here: accept implies the old result drained.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.r_hi      = r_hi_q;
    assign bus.zero      = z_q;
    assign bus.carry     = c_q;
    assign bus.negative  = n_q;
    assign bus.overflow  = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan vectors plus random traffic against alu_seq
// at WIDTH=32, checked through an expected-result queue.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W  = 32;
    localparam int FW = 2*W + 4;   // {r_hi, r, zero, carry, negative, overflow}
    localparam int EW = FW + 8;    // plus edges from accept edge to first out_valid

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ready_mode = 0;    // 0: always ready, 1: random, 2: stalled
    logic       head_seen = 1'b0;
    longint     last_accept_t = 0;
    longint     t_first;
    logic [EW-1:0] exp_q[$];
    longint        t_q[$];
    logic [EW-1:0] mon_head;
    logic [FW-1:0] mon_got;
    longint        mon_lat;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int lat, input logic [W-1:0] rh, input logic [W-1:0] rr,
                                         input logic z, input logic c, input logic n, input logic v);
        return {8'(lat), rh, rr, z, c, n, v};
    endfunction

    // Reference model built from plain arithmetic.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
        logic [W:0]     s;
        logic [W-1:0]   rr;
        logic [63:0]    p;
        logic [4:0]     sh;
        logic           c;
        int             sa, sbv;
        rr = '0; c = 1'b0; sh = a[4:0];
        case (op)
            5'h00: begin s = {1'b0, a} + {1'b0, b}; return mk(0, 0, s[W-1:0], s[W-1:0] == 0, s[W], s[W-1], 0); end
            5'h02: begin rr = a + b; return mk(0, 0, rr, rr == 0, 0, rr[31], (a[31] == b[31]) && (rr[31] != a[31])); end
            5'h01: begin rr = a - b; return mk(0, 0, rr, rr == 0, a < b, rr[31], 0); end
            5'h03: begin rr = a - b; return mk(0, 0, rr, rr == 0, 0, rr[31], (a[31] != b[31]) && (rr[31] != a[31])); end
            5'h04: rr = a & b;
            5'h05: rr = a | b;
            5'h06: rr = a ^ b;
            5'h07: rr = ~(a | b);
            5'h08, 5'h09: rr = b << 16;
            5'h0B: return mk(0, 0, {31'b0, $signed(a) < $signed(b)}, a == b, 0, $signed(a) < $signed(b), 0);
            5'h0A: return mk(0, 0, {31'b0, a < b}, a == b, a < b, 0, 0);
            5'h0C: begin rr = $signed(b) >>> sh; c = (sh == 0) ? 1'b0 : b[sh-1]; end
            5'h0D: begin rr = b >> sh; c = (sh == 0) ? 1'b0 : b[sh-1]; end
            5'h0E, 5'h0F: begin rr = b << sh; c = (sh == 0) ? 1'b0 : b[32-sh]; end
            5'h10: begin
                p = {32'b0, a} * {32'b0, b};
                return mk(W+1, p[63:32], p[31:0], p == 0, 0, p[63], p[63:32] != 0);
            end
            5'h11: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return mk(W+1, p[63:32], p[31:0], p == 0, 0, p[63], p[63:32] != {32{p[31]}});
            end
`ifdef ALU_SEQ_DIV_EN
            5'h12: begin
                if (b == 0) return mk(W+1, a, '1, 0, 0, 1, 1);
                rr = a / b;
                return mk(W+1, a % b, rr, rr == 0, 0, rr[31], 0);
            end
            5'h13: begin
                if (b == 0) return mk(W+1, a, '1, 0, 0, 1, 1);
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return mk(W+1, 0, 32'h80000000, 0, 0, 1, 1);
                sa = a; sbv = b;
                rr = sa / sbv;
                return mk(W+1, sa % sbv, rr, rr == 0, 0, rr[31], 0);
            end
`endif
            default: return mk(0, 0, 0, 0, 0, 0, 0);
        endcase
        return mk(0, 0, rr, rr == 0, c, rr[31], 0);
    endfunction

    // out_ready driver, changed just after each rising edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0)      bus.out_ready = 1'b1;
            else if (ready_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
            else                      bus.out_ready = 1'b0;
        end
    end

    // Scoreboard: compare every visible result with the queue head.
    always @(negedge clk) begin
        if (rst) begin
            head_seen = 1'b0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", EW'(bus.out_valid), 0);
            end else begin
                mon_head = exp_q[0];
                mon_got  = {bus.r_hi, bus.r, bus.zero, bus.carry, bus.negative, bus.overflow};
                check("result", EW'(mon_got), EW'(mon_head[FW-1:0]));
                if (!head_seen) begin
                    mon_lat = ($time - t_q[0] - 5) / 10;
                    check("latency", EW'(mon_lat), EW'(mon_head[EW-1:FW]));
                    head_seen = 1'b1;
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(t_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Driver: present a request and push its expectation on the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op, input logic [EW-1:0] exp);
        int waited = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", EW'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(exp);
            t_q.push_back($time);
            last_accept_t = $time;
            #1;
            bus.in_valid = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.op = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", EW'(exp_q.size()), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        logic [4:0]   rop;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", EW'(bus.out_valid), 0);
        check("rst_busy", EW'(bus.busy), 0);
        check("rst_in_ready", EW'(bus.in_ready), 1);
        check("rst_state", EW'(dbg_state), 0);
        check("rst_outputs", EW'({bus.r_hi, bus.r, bus.zero, bus.carry, bus.negative, bus.overflow}), 0);

        // Single-cycle test-plan vectors, back to back.
        send(32'h7FFFFFFF, 32'h1, 5'h02, mk(0, 0, 32'h80000000, 0, 0, 1, 1));
        t_first = last_accept_t;
        send(32'h3, 32'h5, 5'h01, mk(0, 0, 32'hFFFFFFFE, 0, 1, 1, 0));
        check("back_to_back_gap", EW'(last_accept_t - t_first), 10);
        send(32'hFFFFFFFF, 32'h1, 5'h0B, mk(0, 0, 32'h1, 0, 0, 1, 0));
        send(32'h4, 32'h80000010, 5'h0C, mk(0, 0, 32'hF8000001, 0, 0, 1, 0));
        send(32'h1, 32'h80000000, 5'h0E, mk(0, 0, 32'h0, 1, 1, 0, 0));
        send(32'hFFFFFFFF, 32'h1, 5'h00, mk(0, 0, 32'h0, 1, 1, 0, 0));
        send(32'h0, 32'h1234ABCD, 5'h08, mk(0, 0, 32'hABCD0000, 0, 0, 1, 0));
        send(32'h1, 32'hFFFFFFFF, 5'h0A, mk(0, 0, 32'h1, 0, 1, 0, 0));
        send(32'h0, 32'h80000001, 5'h0D, mk(0, 0, 32'h80000001, 0, 0, 1, 0));
        send(32'h5, 32'h6, 5'h14, mk(0, 0, 32'h0, 0, 0, 0, 0));
        wait_drain();

        // MUL: stalls the request side for the whole operation.
        send(32'hFFFFFFFD, 32'h7, 5'h11, mk(W+1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 1, 0));
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            check("mul_in_ready", EW'(bus.in_ready), 0);
            check("mul_busy", EW'(bus.busy), 1);
        end
        wait_drain();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 5'h10, mk(W+1, 32'hFFFFFFFE, 32'h1, 0, 0, 1, 1));

        // Divide vectors.
`ifdef ALU_SEQ_DIV_EN
        send(32'hFFFFFFF9, 32'h2, 5'h13, mk(W+1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 1, 0));
        send(32'h1234, 32'h0, 5'h12, mk(W+1, 32'h1234, 32'hFFFFFFFF, 0, 0, 1, 1));
        send(32'h80000000, 32'hFFFFFFFF, 5'h13, mk(W+1, 32'h0, 32'h80000000, 0, 0, 1, 1));
`else
        send(32'hFFFFFFF9, 32'h2, 5'h13, mk(0, 0, 0, 0, 0, 0, 0));
        send(32'h1234, 32'h0, 5'h12, mk(0, 0, 0, 0, 0, 0, 0));
        send(32'h80000000, 32'hFFFFFFFF, 5'h13, mk(0, 0, 0, 0, 0, 0, 0));
`endif
        wait_drain();

        // Result held while the consumer stalls.
        ready_mode = 2;
        send(32'h5, 32'h7, 5'h00, mk(0, 0, 32'hC, 0, 0, 0, 0));
        repeat (3) begin
            @(negedge clk);
            check("hold_in_ready", EW'(bus.in_ready), 0);
            check("hold_out_valid", EW'(bus.out_valid), 1);
        end
        ready_mode = 0;
        wait_drain();

        // Reset in the middle of a multiply aborts it.
        send(32'h12345, 32'h6789, 5'h11, mk(W+1, 0, 0, 0, 0, 0, 0));
        repeat (4) @(negedge clk);
        check("abort_busy_before", EW'(bus.busy), 1);
        rst = 1'b1;
        exp_q.delete();
        t_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", EW'(bus.out_valid), 0);
        check("abort_busy", EW'(bus.busy), 0);
        check("abort_in_ready", EW'(bus.in_ready), 1);
        check("abort_state", EW'(dbg_state), 0);
        send(32'h10, 32'h20, 5'h02, mk(0, 0, 32'h30, 0, 0, 0, 0));
        wait_drain();

        // Random traffic with random consumer stalls.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra  = pick();
            rb  = pick();
            rop = 5'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ra, rb, rop, model(ra, rb, rop));
        end
        ready_mode = 0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, pipelined successor to the team's combinational 32-bit ALU. It keeps the 4-bit `aluc` operation set unchanged for single-cycle operations and adds iterative multiply and divide. Operands arrive on a valid/ready input and leave through a one-entry registered output with valid/ready. It sits between the CPU decode/register-read stage and writeback, and can stall the pipeline through `in_ready` while a multi-cycle operation runs.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, 8 or more.
- `SHAMT_W`, default $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand/op request.
- `in_ready` output 1: block can accept a request this cycle.
- `a` input WIDTH: operand 1. Low SHAMT_W bits give the shift amount for shift ops.
- `b` input WIDTH: operand 2. It is the shifted value for shift ops.
- `op` input 5: op[4]=0 selects a single-cycle `aluc` op; op[4]=1 selects an iterative op.
- `out_valid` output 1: result registered and held.
- `out_ready` input 1: consumer takes the result.
- `r` output WIDTH: result, or low product, or quotient.
- `r_hi` output WIDTH: high product, or remainder. 0 for single-cycle ops.
- `zero`, `carry`, `negative`, `overflow` output 1 each: flags, registered with `r`.
- `busy` output 1: iterative op in progress.

## Operation
- States:
  - IDLE: single-cycle ops are accepted here.
  - ITER: WIDTH shift/add or shift/subtract steps.
  - FIX: sign correction and flags.
  - IDLE is re-entered after FIX.
- Accept when `in_valid && in_ready`. `in_ready` = state IDLE && (!out_valid || out_ready).
- Single-cycle ops (op[4]=0, `aluc`=op[3:0]):
  - 0000 ADDU: carry = carry-out.
  - 0010 ADD: overflow on signed overflow.
  - 0001 SUBU: carry = borrow (a<b unsigned).
  - 0011 SUB: overflow on signed overflow.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1011 SLT: r = negative = signed a<b; zero = (a==b).
  - 1010 SLTU: r = carry = unsigned a<b; zero = (a==b).
  - 1100 SRA, 1101 SRL, 111x SLL: shift b by a[SHAMT_W-1:0]. carry = last bit shifted out; carry = 0 when amount is 0.
  - Flags not listed above are 0. zero and negative derive from r, except SLT/SLTU.
- Iterative ops (op[4]=1):
  - 10000 MULU, 10001 MUL (signed): {r_hi,r} = full 2·WIDTH product. overflow=1 when r_hi is not the zero-extension (MULU) or sign-extension (MUL) of r. zero = whole product == 0. negative = r_hi[WIDTH-1].
  - 10010 DIVU, 10011 DIV (signed, truncating): r = quotient, r_hi = remainder. Remainder takes the sign of the dividend a; divisor is b.
  - Divide by zero: r = all ones, r_hi = a, overflow=1.
  - DIV of MIN by -1: r = MIN, r_hi = 0, overflow=1.
  - 101xx, 11xxx are reserved: r=r_hi=0, all flags 0, single-cycle.
- Operands are latched at accept; input changes afterwards are ignored.
- Output register holds r/flags stable while out_valid && !out_ready.

## Timing
- Reset values:
  - state IDLE.
  - out_valid=0, busy=0, in_ready=1 after reset deassertion.
  - r=r_hi=0, all flags 0, iteration counter 0.
- Reset asserted mid-ITER aborts the op. No result is produced.
- Single-cycle latency 1: out_valid is high immediately after the accepting edge.
- Back-to-back single-cycle ops run at 1/cycle when out_ready=1.
- Iterative latency WIDTH+1:
  - accept edge k enters ITER, busy=1.
  - edges k+1..k+WIDTH perform steps.
  - edge k+WIDTH+1 is FIX: result registered, out_valid=1, busy=0, back to IDLE.
- in_ready=0 throughout ITER/FIX.
- The next op is accepted in the cycle after FIX if the output is drained.
- Accepting with out_valid=1 && out_ready=1 on the same edge replaces the output (single-cycle) or clears out_valid (iterative start).

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU/DIV are built as above.
- `ALU_SEQ_DIV_EN` undefined:
  - no divider hardware.
  - 10010/10011 behave as reserved ops (1-cycle, r=r_hi=0, flags 0).
  - MULU/MUL are unchanged.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> r=0x80000000, overflow=1, negative=1, carry=0, out_valid next cycle.
- SUBU a=3 b=5 -> r=0xFFFFFFFE, carry=1; SLT a=0xFFFFFFFF b=1 -> r=1, negative=1, zero=0.
- SRA a=4 b=0x80000010 -> r=0xF8000001, carry=0; SLL a=1 b=0x80000000 -> r=0, carry=1, zero=1.
- MUL a=-3 b=7 -> r=0xFFFFFFEB, r_hi=0xFFFFFFFF, overflow=0, out_valid exactly 33 cycles after accept, in_ready=0 meanwhile. MULU 0xFFFFFFFF², which gives r=1, r_hi=0xFFFFFFFE, overflow=1.
- DIV a=-7 b=2 -> r=-3, r_hi=-1. DIVU b=0 -> r=0xFFFFFFFF, r_hi=a, overflow=1. Without `ALU_SEQ_DIV_EN`, the same stimulus gives r=0 in 1 cycle.
- WIDTH=8, MUL started, then rst pulsed at step 4 -> out_valid=0, busy=0, in_ready=1. Hold out_ready=0 after ADDU -> result held stable and in_ready=0 until drained.
